// File: rtl/operand_seq_ctrl_pkg.sv
// Shared definitions for the operand sequencing controller: state encoding
// (also driven straight onto the LED state code) and its width.
package operand_seq_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    GET_A = 3'd0,
    GET_B = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    SHOW  = 3'd4,
    ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/operand_seq_ctrl_edge_rise.sv
// Rising-edge detector for a debounced button level. The previous-level
// register resets high so a button held through reset release is not an event.
module edge_rise (
  input  logic CLK,
  input  logic RST,
  input  logic level,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  // Track the last sampled level.
  always_comb begin
    prev_d = level;
  end

  // Previous-level register, async active-low reset to 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) prev_q <= 1'b1;
    else      prev_q <= prev_d;
  end

  assign pulse = level & ~prev_q;

endmodule

// File: rtl/operand_seq_ctrl.sv
// Operand sequencing controller: captures two operands from switches on
// enter presses, starts an external multiplier, captures and shows the
// product. Clear returns to GET_A from anywhere and zeroes the data path.
// Optional feature: define OPSEQ_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles and enter ERR when the multiplier never answers.
module operand_seq_ctrl
  import operand_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     sw_data,
  input  logic                 btn_enter,
  input  logic                 btn_clear,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_start,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_prod,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_valid,
  output logic [STATE_W-1:0]   state_code,
  output logic                 error
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("operand_seq_ctrl: TIMEOUT must be at least 2");
  end

  logic enter_pulse;
  logic clear_pulse;

  edge_rise u_enter_edge (
    .CLK   (CLK),
    .RST   (RST),
    .level (btn_enter),
    .pulse (enter_pulse)
  );

  edge_rise u_clear_edge (
    .CLK   (CLK),
    .RST   (RST),
    .level (btn_clear),
    .pulse (clear_pulse)
  );

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   mul_a_q,  mul_a_d;
  logic [WIDTH-1:0]   mul_b_q,  mul_b_d;
  logic [2*WIDTH-1:0] result_q, result_d;

`ifdef OPSEQ_TIMEOUT_EN
  localparam int unsigned      CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state, data capture and start strobe; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    result_d  = result_q;
    mul_start = (state_q == START);
`ifdef OPSEQ_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    if (clear_pulse) begin
      state_d  = GET_A;
      mul_a_d  = '0;
      mul_b_d  = '0;
      result_d = '0;
    end else begin
      case (state_q)
        GET_A: if (enter_pulse) begin
          mul_a_d = sw_data;
          state_d = GET_B;
        end
        GET_B: if (enter_pulse) begin
          mul_b_d = sw_data;
          state_d = START;
        end
        START: begin
`ifdef OPSEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            result_d = mul_prod;
            state_d  = SHOW;
          end
`ifdef OPSEQ_TIMEOUT_EN
          else if (cnt_q == CNT_MAX) state_d = ERR;
          else                       cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
        SHOW: if (enter_pulse) state_d = GET_A;
`ifdef OPSEQ_TIMEOUT_EN
        ERR:  if (enter_pulse) state_d = GET_A;
`endif
        default: state_d = GET_A;
      endcase
    end
  end

  // State and data registers, async active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= GET_A;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      result_q <= result_d;
    end
  end

`ifdef OPSEQ_TIMEOUT_EN
  // WAIT-cycle timeout counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign error = (state_q == ERR);
`else
  assign error = '0;
`endif

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign result       = result_q;
  assign result_valid = (state_q == SHOW);
  assign state_code   = state_q;

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Scoreboard bench for operand_seq_ctrl. Operand pairs and products are
// queued when stimulus is issued; a negedge monitor pops and compares when
// the DUT pulses mul_start or presents a new result. Timeout checks follow
// OPSEQ_TIMEOUT_EN.
module tb_operand_seq_ctrl;

  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [W-1:0]   sw_data = '0;
  logic           btn_enter = 1'b0;
  logic           btn_clear = 1'b0;
  logic [W-1:0]   mul_a, mul_b;
  logic           mul_start;
  logic           mul_done = 1'b0;
  logic [2*W-1:0] mul_prod = '0;
  logic [2*W-1:0] result;
  logic           result_valid;
  logic [2:0]     state_code;
  logic           error;

  operand_seq_ctrl #(.WIDTH(W), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .sw_data(sw_data), .btn_enter(btn_enter),
    .btn_clear(btn_clear), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_done(mul_done), .mul_prod(mul_prod), .result(result),
    .result_valid(result_valid), .state_code(state_code), .error(error)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] exp_ops[$];
  logic [2*W-1:0] exp_res[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare operands at each start strobe and product at each new result.
  logic prev_start = 1'b0;
  logic prev_valid = 1'b0;
  always @(negedge CLK) begin
    if (mul_start) begin
      check("start_single_cycle", 32'(prev_start), 32'd0);
      if (exp_ops.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ops_unexpected: got a=%0h b=%0h expected none", mul_a, mul_b);
      end else begin
        check("operands", {mul_a, mul_b}, exp_ops.pop_front());
      end
    end
    if (result_valid && !prev_valid) begin
      if (exp_res.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL result_unexpected: got %0h expected none", result);
      end else begin
        check("result", result, exp_res.pop_front());
      end
    end
    prev_start <= mul_start;
    prev_valid <= result_valid;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press_enter(input logic [W-1:0] v);
    sw_data = v;
    btn_enter = 1'b1;
    tick();
    btn_enter = 1'b0;
    tick();
  endtask

  task automatic wait_state(input logic [2:0] s);
    for (int i = 0; i < 8 && state_code != s; i++) tick();
    check("reach_state", state_code, s);
  endtask

  task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    press_enter(a);
    exp_ops.push_back({a, b});
    press_enter(b);
    wait_state(3'd3);
  endtask

  task automatic finish_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    btn_enter = 1'b0;
    exp_res.push_back((2*W)'(a) * (2*W)'(b));
    mul_done = 1'b1;
    mul_prod = (2*W)'(mul_a) * (2*W)'(mul_b);
    tick();
    mul_done = 1'b0;
    mul_prod = (2*W)'($urandom);
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    load_ops(a, b);
    for (int i = 0; i < lat; i++) begin
      btn_enter = 1'($urandom_range(0, 1));
      tick();
    end
    finish_mul(a, b);
    check("show_state", state_code, 3'd4);
    check("show_valid", result_valid, 1'b1);
    press_enter(W'($urandom));
    check("back_get_a", state_code, 3'd0);
    check("valid_drop", result_valid, 1'b0);
    check("result_held", result, (2*W)'(a) * (2*W)'(b));
  endtask

  initial begin
    // Reset with enter held through release: no capture.
    btn_enter = 1'b1;
    sw_data = 8'hA5;
    repeat (3) tick();
    check("rst_state", state_code, 3'd0);
    check("rst_mul_a", mul_a, 8'd0);
    check("rst_mul_b", mul_b, 8'd0);
    check("rst_result", result, 16'd0);
    check("rst_valid", result_valid, 1'b0);
    check("rst_start", mul_start, 1'b0);
    check("rst_error", error, 1'b0);
    RST = 1'b1;
    repeat (5) tick();
    check("held_enter_state", state_code, 3'd0);
    check("held_enter_mul_a", mul_a, 8'd0);
    btn_enter = 1'b0;
    tick();

    // Directed 12 x 11.
    run_txn(8'd12, 8'd11, 2);
    check("dir_mul_a", mul_a, 8'd12);
    check("dir_mul_b", mul_b, 8'd11);

    // Enter held 500 cycles: exactly one capture.
    sw_data = 8'h5A;
    btn_enter = 1'b1;
    tick();
    sw_data = 8'h33;
    repeat (499) tick();
    check("hold_state", state_code, 3'd1);
    check("hold_mul_a", mul_a, 8'h5A);
    check("hold_mul_b", mul_b, 8'd11);
    btn_enter = 1'b0;
    tick();

    // Clear and enter together in GET_B: clear wins.
    sw_data = 8'h77;
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    tick();
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick();
    check("clr_state", state_code, 3'd0);
    check("clr_mul_a", mul_a, 8'd0);
    check("clr_mul_b", mul_b, 8'd0);
    check("clr_result", result, 16'd0);

    // Randomized transactions.
    for (int t = 0; t < 20; t++)
      run_txn(W'($urandom), W'($urandom), int'($urandom_range(0, 5)));

    // Reset mid-WAIT, then a late done must be ignored.
    load_ops(8'd200, 8'd3);
    repeat (2) tick();
    #2 RST = 1'b0;
    tick();
    check("midrst_state", state_code, 3'd0);
    check("midrst_result", result, 16'd0);
    RST = 1'b1;
    mul_done = 1'b1;
    mul_prod = 16'hBEEF;
    repeat (3) tick();
    mul_done = 1'b0;
    check("late_done_state", state_code, 3'd0);
    check("late_done_result", result, 16'd0);
    check("late_done_valid", result_valid, 1'b0);
    check("late_done_mul_a", mul_a, 8'd0);

`ifdef OPSEQ_TIMEOUT_EN
    // No done: ERR after 16 WAIT cycles, enter leaves it.
    load_ops(8'd7, 8'd9);
    repeat (15) tick();
    check("to_still_wait", state_code, 3'd3);
    check("to_no_error_yet", error, 1'b0);
    tick();
    check("to_err_state", state_code, 3'd5);
    check("to_error", error, 1'b1);
    press_enter(8'd1);
    check("to_exit_state", state_code, 3'd0);
    check("to_exit_error", error, 1'b0);
    // Done on the final WAIT cycle wins over timeout.
    load_ops(8'd13, 8'd17);
    repeat (15) tick();
    finish_mul(8'd13, 8'd17);
    check("to_done_wins", state_code, 3'd4);
    check("to_done_no_err", error, 1'b0);
    press_enter(8'd0);
`else
    // Without timeout, WAIT persists indefinitely.
    load_ops(8'd7, 8'd9);
    repeat (40) tick();
    check("nto_still_wait", state_code, 3'd3);
    check("nto_error", error, 1'b0);
    finish_mul(8'd7, 8'd9);
    check("nto_show", state_code, 3'd4);
    press_enter(8'd0);
`endif

    tick();
    check("ops_left", exp_ops.size(), 32'd0);
    check("res_left", exp_res.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_seq_ctrl.md
OPERAND_SEQ_CTRL -- requirements
Module: operand_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum cycles spent waiting for the multiplier done signal.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on posedge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sw_data  input  WIDTH  operand value from slide switches.
REQ-006 SHALL have port btn_enter  input  1  debounced enter button level, active-high.
REQ-007 SHALL have port btn_clear  input  1  debounced clear button level, active-high.
REQ-008 SHALL have port mul_a, mul_b  output  WIDTH each  registered operands to the multiplier.
REQ-009 SHALL have port mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-010 SHALL have port mul_done  input  1  multiplier completion, sampled only in WAIT.
REQ-011 SHALL have port mul_prod  input  2*WIDTH  multiplier product, valid while mul_done=1.
REQ-012 SHALL have port result  output  2*WIDTH  captured product.
REQ-013 SHALL have port result_valid  output  1  high while result is displayable.
REQ-014 SHALL have port state_code  output  3  current FSM state encoding for LEDs.
REQ-015 SHALL have port error  output  1  high while in ERR.

Function
REQ-016 SHALL detect enter/clear rising edges with a registered previous level; one edge = one event, regardless of how long the button is held.
REQ-017 SHALL implement states GET_A=0, GET_B=1, START=2, WAIT=3, SHOW=4, ERR=5.
REQ-018 GET_A: on enter edge, mul_a <= sw_data, go to GET_B.
REQ-019 GET_B: on enter edge, mul_b <= sw_data, go to START.
REQ-020 START: mul_start=1 for exactly that one cycle, clear the timeout counter, go to WAIT unconditionally; mul_done in START is ignored.
REQ-021 WAIT: on mul_done, result <= mul_prod, go to SHOW; otherwise increment the timeout counter.
REQ-022 SHOW: result_valid=1; on enter edge, go to GET_A with result and operands held until overwritten.
REQ-023 Enter edges in START and WAIT SHALL be ignored.
REQ-024 A clear edge in any state SHALL go to GET_A, zero mul_a, mul_b and result, and deassert result_valid and error the next cycle.
REQ-025 Clear and enter edges in the same cycle: clear SHALL win.
REQ-026 mul_start SHALL be combinational from state==START only and SHALL never be high for two consecutive cycles.

Reset
REQ-027 With RST low, SHALL force state GET_A, mul_a=0, mul_b=0, result=0, result_valid=0, mul_start=0, error=0, timeout counter=0.
REQ-028 Previous-level edge registers SHALL reset to 1, so a button held through reset release produces no event.
REQ-029 Reset asserted mid-WAIT SHALL abandon the operation; a late mul_done after reset SHALL be ignored in GET_A.

Configuration
REQ-030 Macro OPSEQ_TIMEOUT_EN defined: in WAIT, counter reaching TIMEOUT-1 without mul_done SHALL go to ERR with error=1; mul_done in that same cycle SHALL win (go to SHOW). ERR exits to GET_A on an enter or clear edge.
REQ-031 Macro undefined: WAIT SHALL wait indefinitely, ERR SHALL be unreachable, error SHALL be tied 0, and no counter SHALL be synthesized.

Structure
REQ-032 A shared package SHALL hold the state encoding constants (GET_A..ERR) and the state_code width.
REQ-033 SHALL instantiate one sub-module, edge_rise (CLK, RST, level -> pulse), once each for enter and clear.

Verification
REQ-034 Reset release with btn_enter held high -> state_code=0, no transition to GET_B.
REQ-035 sw_data=8'd12 plus enter edge, then sw_data=8'd11 plus enter edge -> mul_a=12, mul_b=11; mul_start high exactly 1 cycle; mul_done with mul_prod=132 -> result=16'd132, result_valid=1, state_code=4.
REQ-036 btn_enter held 500 cycles in GET_A -> exactly one capture, state GET_B.
REQ-037 Clear and enter edges in the same cycle in GET_B -> state GET_A, mul_a=0.
REQ-038 OPSEQ_TIMEOUT_EN, TIMEOUT=16, no mul_done -> error=1 and state_code=5 after 16 WAIT cycles; enter edge -> GET_A with error=0.
REQ-039 RST pulsed low mid-WAIT, then mul_done=1 -> remains in GET_A, result=0.
